mix_frame_sched: RTL and testbench

MIX_FRAME_SCHED -- requirements
Module: mix_frame_sched

---
 rtl/mix_frame_sched.sv | 90 +++++++++
 tb/tb_mix_frame_sched.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mix_frame_sched.sv
// mix_frame_sched: round-robin TDM scheduler merging N sample channels into one stream with optional zero-fill on underflow
//   clk, rst                 : clock, synchronous active-high reset
//   enable                   : start/continue frame scheduling (a frame always completes once started)
//   s_axis_tdata/tvalid/tready : per-channel sample inputs, only the current channel is ever ready
//   m_axis_tdata/tid/tlast/tvalid/tready : TDM output stream, tlast on channel N-1
//   busy                     : scheduler not idle
//   underflow_cnt            : saturating count of zero-filled samples
module mix_frame_sched #(
    parameter int DW      = 24,
    parameter int N       = 4,
    parameter int TIDW    = 8,
    parameter int TIMEOUT = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic signed [DW-1:0]   s_axis_tdata [N],
    input  logic [N-1:0]           s_axis_tvalid,
    output logic [N-1:0]           s_axis_tready,
    output logic signed [DW-1:0]   m_axis_tdata,
    output logic [TIDW-1:0]        m_axis_tid,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   busy,
    output logic [15:0]            underflow_cnt
);
    localparam int CW = $clog2(N);
    localparam int WW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [WW-1:0] TO = WW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t        state_q;
    logic [CW-1:0] ch_q;
    logic [WW-1:0] wait_q;
    logic          open_w, slot_free, ch_valid, take, fill, load, last;

    // A disabled RUN sitting on channel 0 is a frame boundary, so it accepts nothing and drops to IDLE.
    always_comb begin
        slot_free = !m_axis_tvalid || m_axis_tready;
        open_w    = !rst && (state_q == FINISH || (state_q == RUN && (enable || ch_q != '0)));
        ch_valid  = s_axis_tvalid[ch_q];
        take      = open_w && slot_free && ch_valid;
        fill      = TIMEOUT > 0 && open_w && slot_free && !ch_valid && wait_q == TO;
        load      = take || fill;
        last      = ch_q == LAST;
        s_axis_tready       = '0;
        s_axis_tready[ch_q] = open_w && slot_free;
    end

    assign busy = state_q != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ch_q          <= '0;
            wait_q        <= '0;
            underflow_cnt <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tid    <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (state_q == IDLE && enable)
                state_q <= RUN;
            else if (state_q == RUN && !enable)
                state_q <= (ch_q == '0 || (load && last)) ? IDLE : FINISH;
            else if (state_q == FINISH && load && last)
                state_q <= IDLE;
            if (load) begin
                m_axis_tdata  <= take ? s_axis_tdata[ch_q] : '0;
                m_axis_tid    <= TIDW'(ch_q);
                m_axis_tlast  <= last;
                m_axis_tvalid <= 1'b1;
                ch_q          <= last ? '0 : ch_q + 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            // Stalled cycles (slot not free) never count toward the timeout.
            if (load)
                wait_q <= '0;
            else if (TIMEOUT > 0 && open_w && slot_free && !ch_valid)
                wait_q <= wait_q + 1'b1;
            if (fill && underflow_cnt != 16'hFFFF)
                underflow_cnt <= underflow_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_mix_frame_sched.sv
// tb_mix_frame_sched: directed self-checking bench for mix_frame_sched (N=4, TIMEOUT=8)
module tb_mix_frame_sched;
    logic               clk = 1'b0;
    logic               rst, enable, mr;
    logic signed [23:0] sd [4];
    logic [3:0]         sv, sr;
    logic signed [23:0] md;
    logic [7:0]         mid;
    logic               ml, mv, busy;
    logic [15:0]        ucnt;
    int                 checks = 0;
    int                 errors = 0;

    mix_frame_sched #(.DW(24), .N(4), .TIDW(8), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .s_axis_tdata(sd), .s_axis_tvalid(sv), .s_axis_tready(sr),
        .m_axis_tdata(md), .m_axis_tid(mid), .m_axis_tlast(ml), .m_axis_tvalid(mv),
        .m_axis_tready(mr), .busy(busy), .underflow_cnt(ucnt)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; enable = 1'b0; sv = 4'h0; mr = 1'b1;
        step; step;
        rst = 1'b0;
        #1;
        checks++; if (mv !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b exp 0", mv); end
        checks++; if (md !== 24'sd0) begin errors++; $display("FAIL reset_tdata got %h exp 0", md); end
        checks++; if (mid !== 8'd0) begin errors++; $display("FAIL reset_tid got %0d exp 0", mid); end
        checks++; if (ml !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b exp 0", ml); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (ucnt !== 16'd0) begin errors++; $display("FAIL reset_ucnt got %0d exp 0", ucnt); end
        checks++; if (sr !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", sr); end
    endtask

    task automatic test_stream;
        logic [7:0] e;
        sv = 4'hF; mr = 1'b1; enable = 1'b1;
        step;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stream_busy got %b exp 1", busy); end
        checks++; if (mv !== 1'b0) begin errors++; $display("FAIL stream_first_tvalid got %b exp 0", mv); end
        checks++; if (sr !== 4'b0001) begin errors++; $display("FAIL stream_ready got %b exp 0001", sr); end
        for (int k = 0; k < 8; k++) begin
            step;
            e = 8'(k % 4);
            checks++; if (mv !== 1'b1) begin errors++; $display("FAIL stream_tvalid k=%0d got %b exp 1", k, mv); end
            checks++; if (mid !== e) begin errors++; $display("FAIL stream_tid k=%0d got %0d exp %0d", k, mid, e); end
            checks++; if (ml !== (e == 8'd3)) begin errors++; $display("FAIL stream_tlast k=%0d got %b exp %b", k, ml, e == 8'd3); end
            checks++; if (md !== sd[e[1:0]]) begin errors++; $display("FAIL stream_tdata k=%0d got %h exp %h", k, md, sd[e[1:0]]); end
        end
        enable = 1'b0;
        step;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stream_stop_busy got %b exp 0", busy); end
        checks++; if (mv !== 1'b0) begin errors++; $display("FAIL stream_stop_tvalid got %b exp 0", mv); end
        checks++; if (sr !== 4'b0000) begin errors++; $display("FAIL stream_stop_ready got %b exp 0000", sr); end
    endtask

    task automatic test_stall;
        sv = 4'hF; mr = 1'b1; enable = 1'b1;
        step; step;
        checks++; if (mid !== 8'd0) begin errors++; $display("FAIL stall_tid0 got %0d exp 0", mid); end
        step;
        checks++; if (mid !== 8'd1) begin errors++; $display("FAIL stall_tid1 got %0d exp 1", mid); end
        mr = 1'b0;
        #1;
        checks++; if (sr !== 4'b0000) begin errors++; $display("FAIL stall_ready_low got %b exp 0000", sr); end
        for (int k = 0; k < 5; k++) begin
            step;
            checks++; if (mv !== 1'b1) begin errors++; $display("FAIL stall_hold_tvalid k=%0d got %b exp 1", k, mv); end
            checks++; if (mid !== 8'd1) begin errors++; $display("FAIL stall_hold_tid k=%0d got %0d exp 1", k, mid); end
            checks++; if (md !== sd[1]) begin errors++; $display("FAIL stall_hold_tdata k=%0d got %h exp %h", k, md, sd[1]); end
            checks++; if (sr !== 4'b0000) begin errors++; $display("FAIL stall_hold_ready k=%0d got %b exp 0000", k, sr); end
        end
        mr = 1'b1;
        #1;
        checks++; if (sr !== 4'b0100) begin errors++; $display("FAIL stall_release_ready got %b exp 0100", sr); end
        step;
        checks++; if (mid !== 8'd2 || md !== sd[2]) begin errors++; $display("FAIL stall_tid2 got %0d/%h exp 2/%h", mid, md, sd[2]); end
        step;
        checks++; if (mid !== 8'd3 || ml !== 1'b1) begin errors++; $display("FAIL stall_tid3 got %0d/%b exp 3/1", mid, ml); end
        enable = 1'b0;
        step;
        checks++; if (busy !== 1'b0 || mv !== 1'b0) begin errors++; $display("FAIL stall_idle got busy=%b tvalid=%b exp 0/0", busy, mv); end
    endtask

    task automatic test_enable_drop;
        sv = 4'hF; mr = 1'b1; enable = 1'b1;
        step; step; step;
        checks++; if (mid !== 8'd1) begin errors++; $display("FAIL drop_pre_tid got %0d exp 1", mid); end
        enable = 1'b0;
        step;
        checks++; if (mid !== 8'd2 || mv !== 1'b1) begin errors++; $display("FAIL drop_tid2 got %0d/%b exp 2/1", mid, mv); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_finish_busy got %b exp 1", busy); end
        step;
        checks++; if (mid !== 8'd3 || ml !== 1'b1 || md !== sd[3]) begin errors++; $display("FAIL drop_tid3 got %0d/%b/%h exp 3/1/%h", mid, ml, md, sd[3]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle_busy got %b exp 0", busy); end
        checks++; if (sr !== 4'b0000) begin errors++; $display("FAIL drop_idle_ready got %b exp 0000", sr); end
        step;
        checks++; if (mv !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL drop_after got tvalid=%b busy=%b exp 0/0", mv, busy); end
    endtask

    task automatic test_timeout;
        sv = 4'b1101; mr = 1'b1; enable = 1'b1;
        step; step;
        checks++; if (mid !== 8'd0) begin errors++; $display("FAIL to_tid0 got %0d exp 0", mid); end
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 8; k++) begin
                step;
                checks++; if (mv !== 1'b0 || sr !== 4'b0010) begin errors++; $display("FAIL to_wait f=%0d k=%0d got tvalid=%b ready=%b exp 0/0010", f, k, mv, sr); end
            end
            step;
            checks++; if (mv !== 1'b1 || mid !== 8'd1 || md !== 24'sd0) begin errors++; $display("FAIL to_fill f=%0d got %b/%0d/%h exp 1/1/0", f, mv, mid, md); end
            checks++; if (ucnt !== 16'(f + 1)) begin errors++; $display("FAIL to_ucnt f=%0d got %0d exp %0d", f, ucnt, f + 1); end
            step;
            checks++; if (mid !== 8'd2 || md !== sd[2]) begin errors++; $display("FAIL to_tid2 f=%0d got %0d/%h exp 2/%h", f, mid, md, sd[2]); end
            step;
            checks++; if (mid !== 8'd3 || ml !== 1'b1) begin errors++; $display("FAIL to_tid3 f=%0d got %0d/%b exp 3/1", f, mid, ml); end
            if (f == 0) begin
                step;
                checks++; if (mid !== 8'd0 || md !== sd[0]) begin errors++; $display("FAIL to_tid0b got %0d/%h exp 0/%h", mid, md, sd[0]); end
            end
        end
        enable = 1'b0;
        step;
        checks++; if (busy !== 1'b0 || ucnt !== 16'd2) begin errors++; $display("FAIL to_end got busy=%b ucnt=%0d exp 0/2", busy, ucnt); end
    endtask

    task automatic test_timeout_race;
        sv = 4'b1101; mr = 1'b1; enable = 1'b1; sd[1] = 24'sh0ABCDE;
        step; step;
        for (int k = 0; k < 8; k++) step;
        checks++; if (mv !== 1'b0) begin errors++; $display("FAIL race_wait got %b exp 0", mv); end
        sv[1] = 1'b1;
        step;
        checks++; if (mv !== 1'b1 || mid !== 8'd1 || md !== 24'sh0ABCDE) begin errors++; $display("FAIL race_real got %b/%0d/%h exp 1/1/0abcde", mv, mid, md); end
        checks++; if (ucnt !== 16'd2) begin errors++; $display("FAIL race_ucnt got %0d exp 2", ucnt); end
        step; step;
        enable = 1'b0;
        step;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL race_end_busy got %b exp 0", busy); end
    endtask

    task automatic test_rst_midframe;
        sv = 4'hF; mr = 1'b1; enable = 1'b1;
        step; step; step; step;
        checks++; if (mv !== 1'b1 || mid !== 8'd2) begin errors++; $display("FAIL rstm_pre got %b/%0d exp 1/2", mv, mid); end
        rst = 1'b1;
        #1;
        checks++; if (sr !== 4'b0000) begin errors++; $display("FAIL rstm_ready_in_rst got %b exp 0000", sr); end
        step;
        checks++; if (mv !== 1'b0 || md !== 24'sd0 || mid !== 8'd0 || ml !== 1'b0) begin errors++; $display("FAIL rstm_outputs got %b/%h/%0d/%b exp 0/0/0/0", mv, md, mid, ml); end
        checks++; if (busy !== 1'b0 || ucnt !== 16'd0 || sr !== 4'b0000) begin errors++; $display("FAIL rstm_state got busy=%b ucnt=%0d ready=%b exp 0/0/0000", busy, ucnt, sr); end
        rst = 1'b0;
        step;
        checks++; if (busy !== 1'b1 || mv !== 1'b0) begin errors++; $display("FAIL rstm_run got busy=%b tvalid=%b exp 1/0", busy, mv); end
        step;
        checks++; if (mv !== 1'b1 || mid !== 8'd0 || md !== sd[0]) begin errors++; $display("FAIL rstm_first got %b/%0d/%h exp 1/0/%h", mv, mid, md, sd[0]); end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; mr = 1'b1; sv = 4'h0;
        sd[0] = 24'sh000011; sd[1] = -24'sd16; sd[2] = 24'sh123456; sd[3] = 24'sh800000;
        test_reset;
        test_stream;
        test_stall;
        test_enable_drop;
        test_timeout;
        test_timeout_race;
        test_rst_midframe;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
